// File: rtl/logic_result_collector.sv
// logic_result_collector
// Consumer end of the 8-bit bitwise-logic result path. Buffers {tag, result}
// pairs from the AND/OR/XOR units in a small FIFO and presents them in order
// to register-file writeback, so a stalled writeback port does not stall issue.
// Optional feature macro: LRC_FLAGS_EN -- when defined, each entry also carries
// a zero flag and a parity flag computed at push time and driven on
// out_zero/out_par. When undefined those ports are tied to 0.

module logic_result_collector #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAGW  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [TAGW-1:0]          in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAGW-1:0]          out_tag,
  output logic                     out_zero,
  output logic                     out_par,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef LRC_FLAGS_EN
  localparam int FW = 2;
`else
  localparam int FW = 0;
`endif
  localparam int EW = TAGW + WIDTH + FW;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          push_w;
  logic          pop_w;
  logic [EW-1:0] entry_wr;
  logic [EW-1:0] head;

  // Flow control depends only on the registered occupancy, never on out_ready,
  // so a full FIFO refuses a push even when a pop happens in the same cycle.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push_w    = in_valid & in_ready;
  assign pop_w     = out_valid & out_ready;
  assign count     = count_q;

  // Entry layout: {tag, data[, zero, par]} with flags in the low bits.
`ifdef LRC_FLAGS_EN
  assign entry_wr = {in_tag, in_data, (in_data == '0), ^in_data};
`else
  assign entry_wr = {in_tag, in_data};
`endif

  // Next-state for pointers and occupancy; power-of-2 depth lets pointers wrap
  // by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_w) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_w)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_w && !pop_w)      count_d = count_q + CW'(1);
    else if (!push_w && pop_w) count_d = count_q - CW'(1);
  end

  // Control state; reset discards every buffered entry and wins over push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are not reset because occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push_w && !rst) mem_q[wr_ptr_q] <= entry_wr;
  end

  // Head of queue drives the writeback side; data is forced to 0 when empty
  // so stale storage never leaks onto the bus.
  assign head     = mem_q[rd_ptr_q];
  assign out_data = out_valid ? head[FW +: WIDTH] : '0;
  assign out_tag  = out_valid ? head[FW+WIDTH +: TAGW] : '0;

`ifdef LRC_FLAGS_EN
  assign out_zero = (out_valid && !rst) ? head[1] : 1'b0;
  assign out_par  = (out_valid && !rst) ? head[0] : 1'b0;
`else
  assign out_zero = 1'b0;
  assign out_par  = 1'b0;
`endif

endmodule

// File: tb/tb_logic_result_collector.sv
// Testbench for logic_result_collector: table-driven vectors with a scoreboard
// queue for data ordering, plus streaming and mid-operation reset sequences.

module tb_logic_result_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_tag;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_tag;
  logic       out_zero;
  logic       out_par;
  logic [2:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] data;
    logic [2:0] tag;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic [2:0] t;
    logic       ordy;
    int         exp_cnt;
  } vec_t;
  vec_t vecs[18];

  always #5 clk = ~clk;

  logic_result_collector #(.WIDTH(8), .DEPTH(4), .TAGW(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_zero(out_zero), .out_par(out_par), .count(count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs
  // mid-cycle, update the scoreboard, then advance past the next rising edge.
  task automatic cycle(input logic r, input logic iv, input logic [7:0] d,
                       input logic [2:0] t, input logic ordy, input int exp_cnt,
                       input string name);
    int  size_at_start;
    sb_t e;
    logic ez, ep;
    rst = r; in_valid = iv; in_data = d; in_tag = t; out_ready = ordy;
    #1;
    size_at_start = sb.size();
    if (exp_cnt >= 0) begin
      chk({name, ".count"}, 32'(count), 32'(exp_cnt));
      chk({name, ".in_ready"}, 32'(in_ready), 32'(exp_cnt != 4));
      chk({name, ".out_valid"}, 32'(out_valid), 32'(exp_cnt != 0));
      if (exp_cnt == 0) begin
        chk({name, ".empty_data"}, 32'(out_data), 32'h0);
        chk({name, ".empty_tag"}, 32'(out_tag), 32'h0);
        chk({name, ".empty_flags"}, 32'({out_zero, out_par}), 32'h0);
      end
    end
    if (!r && out_valid) begin
      if (sb.size() == 0) begin
        chk({name, ".unexpected_head"}, 32'(out_valid), 32'h0);
      end else begin
        e = sb[0];
`ifdef LRC_FLAGS_EN
        ez = (e.data == 8'h00);
        ep = ^e.data;
`else
        ez = 1'b0;
        ep = 1'b0;
`endif
        chk({name, ".data"}, 32'(out_data), 32'(e.data));
        chk({name, ".tag"}, 32'(out_tag), 32'(e.tag));
        chk({name, ".flags"}, 32'({out_zero, out_par}), 32'({ez, ep}));
        $display("cycle %s: head data=%02h tag=%0d pop=%0d", name, out_data, out_tag, ordy);
        if (ordy) void'(sb.pop_front());
      end
    end
    if (r) begin
      sb.delete();
    end else if (iv && size_at_start != 4) begin
      e.data = d;
      e.tag  = t;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0;
    @(negedge clk);

    // Reset: two cycles high, then idle with everything checked.
    cycle(1'b1, 1'b0, 8'h00, 3'd0, 1'b0, -1, "reset0");
    cycle(1'b1, 1'b0, 8'h00, 3'd0, 1'b0, -1, "reset1");
    cycle(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 0, "post_reset");

    // Ordering, full, and full-with-simultaneous-pop vectors.
    vecs[0]  = '{1'b1, 8'h0F, 3'd1, 1'b0, 0};
    vecs[1]  = '{1'b1, 8'hA5, 3'd2, 1'b0, 1};
    vecs[2]  = '{1'b1, 8'h00, 3'd3, 1'b0, 2};
    vecs[3]  = '{1'b0, 8'h00, 3'd0, 1'b1, 3};
    vecs[4]  = '{1'b0, 8'h00, 3'd0, 1'b1, 2};
    vecs[5]  = '{1'b0, 8'h00, 3'd0, 1'b1, 1};
    vecs[6]  = '{1'b0, 8'h00, 3'd0, 1'b0, 0};
    vecs[7]  = '{1'b1, 8'h11, 3'd4, 1'b0, 0};
    vecs[8]  = '{1'b1, 8'h22, 3'd5, 1'b0, 1};
    vecs[9]  = '{1'b1, 8'h33, 3'd6, 1'b0, 2};
    vecs[10] = '{1'b1, 8'h44, 3'd7, 1'b0, 3};
    vecs[11] = '{1'b1, 8'h77, 3'd0, 1'b0, 4};
    vecs[12] = '{1'b1, 8'h88, 3'd1, 1'b1, 4};
    vecs[13] = '{1'b1, 8'h88, 3'd1, 1'b1, 3};
    vecs[14] = '{1'b0, 8'h00, 3'd0, 1'b1, 3};
    vecs[15] = '{1'b0, 8'h00, 3'd0, 1'b1, 2};
    vecs[16] = '{1'b0, 8'h00, 3'd0, 1'b1, 1};
    vecs[17] = '{1'b0, 8'h00, 3'd0, 1'b0, 0};
    for (int i = 0; i < 18; i++) begin
      cycle(1'b0, vecs[i].iv, vecs[i].d, vecs[i].t, vecs[i].ordy, vecs[i].exp_cnt,
            $sformatf("vec%0d", i));
    end

    // Streaming across pointer wrap: count settles at 1, one-cycle latency.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 8'(i), 3'(i), 1'b1, (i == 0) ? 0 : 1, $sformatf("stream%0d", i));
    end
    cycle(1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1, "stream_drain");
    cycle(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 0, "stream_empty");

    // Mid-operation reset with concurrent push and pop.
    cycle(1'b0, 1'b1, 8'hC1, 3'd1, 1'b0, 0, "mid0");
    cycle(1'b0, 1'b1, 8'hC2, 3'd2, 1'b0, 1, "mid1");
    cycle(1'b0, 1'b1, 8'hC3, 3'd3, 1'b0, 2, "mid2");
    cycle(1'b1, 1'b1, 8'hC4, 3'd4, 1'b1, 3, "mid_rst");
    cycle(1'b0, 1'b1, 8'h5A, 3'd6, 1'b0, 0, "mid_after");
    cycle(1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1, "mid_pop");
    cycle(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 0, "mid_empty");
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
